mul_div_unit: RTL and testbench

Iterative 32-bit multiply/divide unit with HI/LO result registers for the single-cycle MIPS datapath. Consumes the two register-file read operands (readData1 as rs, readData2 as rt) and executes MULT, MULTU, DIV and DIVU over multiple cycles. It holds the 64-bit result in HI/LO for later MFHI/MFLO and accepts MTHI/MTLO writes. Control stalls the PC while `busy` is high.

---
 rtl/mul_div_unit_if.sv | 29 ++
 rtl/mul_div_unit.sv | 150 +++++++++++++++
 tb/tb_mul_div_unit.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
// Handshake/data bundle between control and the mul/div unit.
// master: start/op/operands/mthi/mtlo/wdata out; slave: busy/done/hi/lo out.
interface mul_div_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] rs_data;
  logic [XLEN-1:0] rt_data;
  logic            mthi;
  logic            mtlo;
  logic [XLEN-1:0] wdata;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data,
    output mthi, mtlo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data,
    input  mthi, mtlo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU with HI/LO registers, 33-cycle latency.
// Ports: clk, rst_n (async low), bus (slave: start/op/rs/rt/mthi/mtlo/wdata in; busy/done/hi/lo out).
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          rst_n,
  mul_div_unit_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  localparam int W2 = 2 * XLEN;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  state_t          state;
  logic            is_div;
  logic            neg_lo;
  logic            neg_hi;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [W2-1:0]   acc;
  logic [CW-1:0]   cnt;
  logic            busy_q;
  logic            done_q;
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;

  // op[0]=0 selects the signed flavours
  logic            sgn_op;
  logic            sign_a;
  logic            sign_b;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            b_zero;

  assign sgn_op = ~bus.op[0];
  assign sign_a = sgn_op & bus.rs_data[XLEN-1];
  assign sign_b = sgn_op & bus.rt_data[XLEN-1];
  assign mag_a  = sign_a ? -bus.rs_data : bus.rs_data;
  assign mag_b  = sign_b ? -bus.rt_data : bus.rt_data;
  assign b_zero = (bus.rt_data == '0);

  // shift-add step: 33-bit sum keeps the carry
  logic [XLEN:0]   mul_sum;
  logic [W2-1:0]   mul_next;

  assign mul_sum  = {1'b0, acc[W2-1:XLEN]} + {1'b0, a_q};
  assign mul_next = b_q[0]
                  ? {mul_sum, acc[XLEN-1:1]}
                  : {1'b0, acc[W2-1:1]};

  // restoring step: dividend bits stream in from a_q's MSB
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;
  logic            no_bor;
  logic [W2-1:0]   div_next;

  assign rem_sh   = {acc[W2-1:XLEN], a_q[XLEN-1]};
  assign diff     = rem_sh - {1'b0, b_q};
  assign no_bor   = ~diff[XLEN];
  assign div_next = {
    no_bor ? diff[XLEN-1:0] : rem_sh[XLEN-1:0],
    acc[XLEN-2:0],
    no_bor
  };

  logic [W2-1:0]   prod_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] quo_fix;

  assign prod_fix = neg_lo ? -acc : acc;
  assign rem_fix  = neg_hi
                  ? -acc[W2-1:XLEN]
                  : acc[W2-1:XLEN];
  assign quo_fix  = neg_lo
                  ? -acc[XLEN-1:0]
                  : acc[XLEN-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            is_div <= bus.op[1];
            a_q    <= mag_a;
            b_q    <= mag_b;
            // x/0 keeps LO all-ones regardless of dividend sign
            neg_lo <= (sign_a ^ sign_b)
                    & ~(bus.op[1] & b_zero);
            neg_hi <= sign_a;
            acc    <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= CALC;
          end else begin
            if (bus.mthi) hi_q <= bus.wdata;
            if (bus.mtlo) lo_q <= bus.wdata;
          end
        end
        CALC: begin
          if (is_div) begin
            acc <= div_next;
            a_q <= {a_q[XLEN-2:0], 1'b0};
          end else begin
            acc <= mul_next;
            b_q <= {1'b0, b_q[XLEN-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(XLEN - 1)) state <= FIN;
        end
        FIN: begin
          if (is_div) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[W2-1:XLEN];
            lo_q <= prod_fix[XLEN-1:0];
          end
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: arithmetic model + directed vectors.
// Model predicts busy/done/hi/lo every cycle; literals pin the model.
module tb_mul_div_unit;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mul_div_unit_if #(.XLEN(32)) bus ();

  mul_div_unit #(.XLEN(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // result of an op from plain arithmetic: {hi, lo}
  function automatic logic [63:0] model(
    input logic [1:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    longint sa, sb, q, r;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      2'd0: begin
        q = sa * sb;
        return q;
      end
      2'd1: begin
        p = ua * ub;
        return p;
      end
      2'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {(a % b), (a / b)};
      end
    endcase
  endfunction

  // cycle model: countdown to a precomputed result
  logic        m_busy, m_done;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_res;
  int          m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_done <= 0;
      m_hi <= 0; m_lo <= 0;
      m_cnt <= 0; m_res <= 0;
    end else begin
      m_done <= 0;
      if (m_cnt == 1) begin
        m_hi <= m_res[63:32];
        m_lo <= m_res[31:0];
        m_done <= 1;
        m_busy <= 0;
        m_cnt <= 0;
      end else if (m_cnt > 1) begin
        m_cnt <= m_cnt - 1;
      end else if (bus.start) begin
        m_res <= model(bus.op, bus.rs_data, bus.rt_data);
        m_cnt <= 33;
        m_busy <= 1;
      end else begin
        if (bus.mthi) m_hi <= bus.wdata;
        if (bus.mtlo) m_lo <= bus.wdata;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (bus.busy !== m_busy || bus.done !== m_done
          || bus.hi !== m_hi || bus.lo !== m_lo) begin
        errors++;
        $display("FAIL cycle busy/done/hi/lo got %b/%b/%h/%h want %b/%b/%h/%h",
                 bus.busy, bus.done, bus.hi, bus.lo,
                 m_busy, m_done, m_hi, m_lo);
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, exp);
    end
  endtask

  // start now, return at the negedge of the done cycle
  task automatic run(input string nm,
                     input logic [1:0] op,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [31:0] ehi,
                     input logic [31:0] elo);
    int nb;
    bit seen;
    nb = 0;
    seen = 0;
    bus.start = 1; bus.op = op;
    bus.rs_data = a; bus.rt_data = b;
    @(posedge clk); #1;
    bus.start = 0;
    bus.rs_data = 32'h5A5A_5A5A;
    bus.rt_data = 32'hA5A5_A5A5;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1;
        break;
      end
      if (bus.busy) nb++;
    end
    chk({nm, "_done"}, 32'(seen), 32'd1);
    chk({nm, "_busy"}, nb, 33);
    chk({nm, "_hi"}, bus.hi, ehi);
    chk({nm, "_lo"}, bus.lo, elo);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.start = 0; bus.op = 0;
    bus.rs_data = 0; bus.rt_data = 0;
    bus.mthi = 0; bus.mtlo = 0; bus.wdata = 0;
    rst_n = 0;
    #1;
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_busy", 32'(bus.busy), 0);
    #20 rst_n = 1;
    @(negedge clk);

    run("mult", 2'd0, 32'd7, 32'hFFFF_FFFD,
        32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run("multu", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'hFFFF_FFFE, 32'h0000_0001);
    run("divu0", 2'd3, 32'd100, 32'd0,
        32'h0000_0064, 32'hFFFF_FFFF);
    run("div", 2'd2, 32'hFFFF_FFF9, 32'd2,
        32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("divovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF,
        32'h0, 32'h8000_0000);
    run("divneg", 2'd2, 32'd100, 32'hFFFF_FFF9,
        32'd2, 32'hFFFF_FFF2);

    @(posedge clk); #1;
    bus.mthi = 1; bus.wdata = 32'h1234;
    @(posedge clk); #1;
    bus.mthi = 0;
    chk("mthi", bus.hi, 32'h1234);

    bus.mtlo = 1; bus.start = 1;
    bus.wdata = 32'hBEEF; bus.op = 0;
    bus.rs_data = 3; bus.rt_data = 4;
    @(posedge clk); #1;
    bus.start = 0; bus.mtlo = 0;
    chk("start_wins", bus.lo, 32'hFFFF_FFF2);
    repeat (5) @(posedge clk);
    #1;
    bus.start = 1; bus.op = 3;
    bus.rs_data = 99; bus.rt_data = 5;
    bus.mtlo = 1; bus.wdata = 32'hDEAD;
    @(posedge clk); #1;
    bus.start = 0; bus.mtlo = 0;
    chk("calc_hold", bus.lo, 32'hFFFF_FFF2);
    for (int i = 0; i < 40 && !bus.done; i++)
      @(negedge clk);
    chk("ign_hi", bus.hi, 0);
    chk("ign_lo", bus.lo, 12);
    run("b2b", 2'd1, 32'h0001_0000, 32'h0001_0000,
        32'h1, 32'h0);

    bus.start = 1; bus.op = 3;
    bus.rs_data = 1000; bus.rt_data = 7;
    @(posedge clk); #1;
    bus.start = 0;
    repeat (9) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_done", 32'(bus.done), 0);
    chk("arst_hi", bus.hi, 0);
    chk("arst_lo", bus.lo, 0);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    run("divu", 2'd3, 32'd1000, 32'd7,
        32'd6, 32'd142);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
